sprite_blitter: RTL and testbench

Writes one sprite from its palette-index ROM into the on-chip frame buffer that the per-sprite mappers and the scan-out path read. A host FSM pulses `start` with a screen position. The block then walks the sprite in raster order: it fetches each index from a synchronous ROM, skips transparent and off-screen pixels, and writes the rest into frame-buffer RAM through a ready/write handshake. It sits on the system clock between the game-logic FSM and the frame-buffer arbiter.

---
 rtl/sprite_blitter_if.sv | 25 ++
 rtl/sprite_blitter.sv | 84 ++++++++
 tb/tb_sprite_blitter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_blitter_if.sv
// Host, sprite-ROM and frame-buffer signals of the sprite blitter.
// The blitter uses the master view; the host/memory side uses the slave view.
interface sprite_blitter_if;
    logic        start;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        busy;
    logic        done;
    logic [10:0] rom_addr;
    logic [4:0]  rom_q;
    logic [16:0] fb_addr;
    logic [4:0]  fb_data;
    logic        fb_we;
    logic        fb_ready;

    modport master (
        input  start, pos_x, pos_y, rom_q, fb_ready,
        output busy, done, rom_addr, fb_addr, fb_data, fb_we
    );

    modport slave (
        output start, pos_x, pos_y, rom_q, fb_ready,
        input  busy, done, rom_addr, fb_addr, fb_data, fb_we
    );
endinterface

// File: rtl/sprite_blitter.sv
// Walks one sprite in raster order, reading palette indices from a synchronous ROM
// and writing the visible, non-transparent ones into the frame buffer.
module sprite_blitter #(
    parameter int         SPR_W  = 21,
    parameter int         SPR_H  = 45,
    parameter int         FB_W   = 320,
    parameter int         FB_H   = 240,
    parameter logic [4:0] TRANSP = 5'd0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    sprite_blitter_if.master     bus
);
    localparam int SX_W = $clog2(SPR_W);
    localparam int SY_W = $clog2(SPR_H);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_WRITE, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [SX_W-1:0] r_sx;
    logic [SY_W-1:0] r_sy;
    logic [9:0]      r_px, r_py;
    logic [4:0]      r_pix;
    logic            w_adv, w_last, w_clip;
    logic [10:0]     w_x, w_y;

    // Screen coordinates carry an extra bit so off-screen pixels clip instead of wrapping.
    assign w_x    = {1'b0, r_px} + 11'(r_sx);
    assign w_y    = {1'b0, r_py} + 11'(r_sy);
    assign w_clip = (w_x >= 11'(FB_W)) || (w_y >= 11'(FB_H));
    assign w_last = (r_sx == SX_W'(SPR_W-1)) && (r_sy == SY_W'(SPR_H-1));

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_clip) w_adv = 1'b1; else w_state_nxt = S_LATCH;
            S_LATCH: if (bus.rom_q == TRANSP) w_adv = 1'b1; else w_state_nxt = S_WRITE;
            S_WRITE: if (bus.fb_ready) w_adv = 1'b1;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_adv) w_state_nxt = w_last ? S_DONE : S_FETCH;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sx  <= '0;
            r_sy  <= '0;
            r_px  <= '0;
            r_py  <= '0;
            r_pix <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_px <= bus.pos_x;
                r_py <= bus.pos_y;
                r_sx <= '0;
                r_sy <= '0;
            end
            if (r_state == S_LATCH) r_pix <= bus.rom_q;
            if (w_adv) begin
                if (r_sx == SX_W'(SPR_W-1)) begin
                    r_sx <= '0;
                    r_sy <= w_last ? '0 : r_sy + 1'b1;
                end else begin
                    r_sx <= r_sx + 1'b1;
                end
            end
        end
    end

    assign bus.busy     = (r_state == S_FETCH) || (r_state == S_LATCH) || (r_state == S_WRITE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.fb_we    = (r_state == S_WRITE);
    assign bus.fb_data  = r_pix;
    assign bus.rom_addr = 11'(r_sy) * 11'(SPR_W) + 11'(r_sx);
    assign bus.fb_addr  = 17'(w_y) * 17'(FB_W) + 17'(w_x);
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model, frame-buffer model, and per-scenario tasks.
module tb_sprite_blitter;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    sprite_blitter_if bus();

    sprite_blitter dut (.Clk(Clk), .Reset(Reset), .bus(bus.master));

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4:0]  mem  [0:76799];
    int unsigned wcnt [0:76799];
    int wr_total = 0, done_total = 0, stall_total = 0, stall_bad = 0, oob_total = 0;
    logic clr_req = 1'b0;
    logic p_stall = 1'b0;
    logic [16:0] p_addr = '0;
    logic [4:0]  p_data = '0;

    int rom_mode = 0;
    logic [4:0] rom_const = 5'd3;
    int rdy_mode = 0;
    int wr_base_rdy = 0;
    logic [15:0] lfsr = 16'hACE1;

    // Synchronous sprite ROM: constant index or (sx+sy)%4 pattern.
    always @(posedge Clk)
        bus.rom_q <= (rom_mode == 0) ? rom_const
                   : 5'(((bus.rom_addr % 11'd21) + (bus.rom_addr / 11'd21)) % 11'd4);

    initial begin
        bus.fb_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            case (rdy_mode)
                0:       bus.fb_ready = 1'b1;
                1:       bus.fb_ready = lfsr[0];
                default: bus.fb_ready = ((wr_total - wr_base_rdy) != 99);
            endcase
        end
    end

    // Frame-buffer model and handshake observer, sampled mid-cycle.
    always @(negedge Clk) begin
        if (clr_req) begin
            for (int i = 0; i < 76800; i++) begin
                mem[i]  <= '0;
                wcnt[i] <= 0;
            end
        end else if (!Reset) begin
            if (bus.fb_we && bus.fb_ready) begin
                wr_total <= wr_total + 1;
                if (bus.fb_addr < 17'd76800) begin
                    mem[bus.fb_addr]  <= bus.fb_data;
                    wcnt[bus.fb_addr] <= wcnt[bus.fb_addr] + 1;
                end else oob_total <= oob_total + 1;
            end
            if (bus.fb_we && !bus.fb_ready) stall_total <= stall_total + 1;
            if (p_stall && (bus.fb_we !== 1'b1 || bus.fb_addr !== p_addr || bus.fb_data !== p_data))
                stall_bad <= stall_bad + 1;
            if (bus.done) done_total <= done_total + 1;
        end
        p_stall <= !Reset && bus.fb_we && !bus.fb_ready;
        p_addr  <= bus.fb_addr;
        p_data  <= bus.fb_data;
    end

    function automatic int pix_val(int mode, int val, int sx, int sy);
        return (mode == 0) ? val : (sx + sy) % 4;
    endfunction

    function automatic int img_bad(int x, int y, int mode, int val);
        int bad, ax, ay, a, v;
        bad = 0;
        for (int sy = 0; sy < 45; sy++)
            for (int sx = 0; sx < 21; sx++) begin
                ax = x + sx; ay = y + sy; v = pix_val(mode, val, sx, sy);
                if (ax < 320 && ay < 240) begin
                    a = ay * 320 + ax;
                    if (v == 0) begin
                        if (wcnt[a] != 0) bad++;
                    end else if (wcnt[a] != 1 || mem[a] != 5'(v)) bad++;
                end
            end
        return bad;
    endfunction

    function automatic int exp_cost(int x, int y, int mode, int val, bit count_writes);
        int c, w;
        c = 0; w = 0;
        for (int sy = 0; sy < 45; sy++)
            for (int sx = 0; sx < 21; sx++)
                if (x + sx >= 320 || y + sy >= 240) c += 1;
                else if (pix_val(mode, val, sx, sy) == 0) c += 2;
                else begin c += 3; w++; end
        return count_writes ? w : c;
    endfunction

    task automatic clear_fb();
        @(negedge Clk); clr_req = 1'b1;
        @(negedge Clk); #1; clr_req = 1'b0;
    endtask

    task automatic run_blit(input logic [9:0] x, input logic [9:0] y, output int cycles,
                            output logic busy_seen, output logic done_seen);
        @(negedge Clk); bus.start = 1'b1; bus.pos_x = x; bus.pos_y = y;
        @(negedge Clk); bus.start = 1'b0;
        busy_seen = bus.busy;
        cycles = 0;
        while (!bus.done && cycles < 20000) begin @(negedge Clk); cycles++; end
        done_seen = bus.done;
        repeat (3) @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_cmp++; if ({bus.busy, bus.done, bus.fb_we} !== 3'b000) begin n_bad++;
            $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {bus.busy, bus.done, bus.fb_we}); end
        n_cmp++; if (bus.rom_addr !== 11'd0 || bus.fb_addr !== 17'd0 || bus.fb_data !== 5'd0) begin n_bad++;
            $display("FAIL reset_addr: rom=%0d fb=%0d data=%0d expected 0", bus.rom_addr, bus.fb_addr, bus.fb_data); end
        @(posedge Clk); #1 Reset = 1'b0;
    endtask

    task automatic test_opaque();
        int cyc, w0, d0; logic bz, dn, bad;
        clear_fb(); rom_mode = 0; rom_const = 5'd3; rdy_mode = 0;
        w0 = wr_total; d0 = done_total;
        run_blit(10'd0, 10'd0, cyc, bz, dn);
        n_cmp++; if (bz !== 1'b1) begin n_bad++; $display("FAIL opaque_busy: got %b expected 1", bz); end
        n_cmp++; if (cyc != 2835 || dn !== 1'b1) begin n_bad++; $display("FAIL opaque_cycles: got %0d expected 2835", cyc); end
        n_cmp++; if (wr_total - w0 != 945) begin n_bad++; $display("FAIL opaque_writes: got %0d expected 945", wr_total - w0); end
        n_cmp++; if (img_bad(0, 0, 0, 3) != 0) begin n_bad++; $display("FAIL opaque_image: bad pixels %0d expected 0", img_bad(0, 0, 0, 3)); end
        n_cmp++; if (done_total - d0 != 1 || bus.busy !== 1'b0) begin n_bad++;
            $display("FAIL opaque_done: pulses %0d busy %b expected 1 and 0", done_total - d0, bus.busy); end
        bad = (wcnt[21] != 0) || (wcnt[44*320+20] != 1);
        n_cmp++; if (bad) begin n_bad++; $display("FAIL opaque_edges: wcnt[21]=%0d wcnt[14100]=%0d expected 0 and 1", wcnt[21], wcnt[44*320+20]); end
    endtask

    task automatic test_pattern();
        int cyc, w0; logic bz, dn;
        clear_fb(); rom_mode = 1; rdy_mode = 0;
        w0 = wr_total;
        run_blit(10'd100, 10'd50, cyc, bz, dn);
        n_cmp++; if (cyc != exp_cost(100, 50, 1, 0, 0)) begin n_bad++;
            $display("FAIL pattern_cycles: got %0d expected %0d", cyc, exp_cost(100, 50, 1, 0, 0)); end
        n_cmp++; if (wr_total - w0 != exp_cost(100, 50, 1, 0, 1)) begin n_bad++;
            $display("FAIL pattern_writes: got %0d expected %0d", wr_total - w0, exp_cost(100, 50, 1, 0, 1)); end
        n_cmp++; if (img_bad(100, 50, 1, 0) != 0) begin n_bad++;
            $display("FAIL pattern_image: bad pixels %0d expected 0", img_bad(100, 50, 1, 0)); end
    endtask

    task automatic test_clip();
        int cyc, w0, o0; logic bz, dn;
        clear_fb(); rom_mode = 0; rom_const = 5'd7; rdy_mode = 0;
        w0 = wr_total; o0 = oob_total;
        run_blit(10'd310, 10'd230, cyc, bz, dn);
        n_cmp++; if (cyc != 1145) begin n_bad++; $display("FAIL clip_cycles: got %0d expected 1145", cyc); end
        n_cmp++; if (wr_total - w0 != 100 || oob_total != o0) begin n_bad++;
            $display("FAIL clip_writes: got %0d (oob %0d) expected 100 (oob 0)", wr_total - w0, oob_total - o0); end
        n_cmp++; if (wcnt[76799] != 1 || mem[76799] !== 5'd7) begin n_bad++;
            $display("FAIL clip_corner: count %0d data %0d expected 1 and 7", wcnt[76799], mem[76799]); end
        n_cmp++; if (wcnt[230*320] != 0 || img_bad(310, 230, 0, 7) != 0) begin n_bad++;
            $display("FAIL clip_wrap: col0 count %0d image bad %0d expected 0 and 0", wcnt[230*320], img_bad(310, 230, 0, 7)); end
    endtask

    task automatic test_stall();
        int cyc, w0, s0, sb0; logic bz, dn;
        clear_fb(); rom_mode = 1; rdy_mode = 1;
        w0 = wr_total; s0 = stall_total; sb0 = stall_bad;
        run_blit(10'd100, 10'd50, cyc, bz, dn);
        rdy_mode = 0;
        n_cmp++; if (stall_total - s0 < 50) begin n_bad++; $display("FAIL stall_count: got %0d expected at least 50", stall_total - s0); end
        n_cmp++; if (stall_bad != sb0) begin n_bad++; $display("FAIL stall_stable: unstable cycles %0d expected 0", stall_bad - sb0); end
        n_cmp++; if (cyc != exp_cost(100, 50, 1, 0, 0) + (stall_total - s0)) begin n_bad++;
            $display("FAIL stall_cycles: got %0d expected %0d", cyc, exp_cost(100, 50, 1, 0, 0) + stall_total - s0); end
        n_cmp++; if (wr_total - w0 != exp_cost(100, 50, 1, 0, 1) || img_bad(100, 50, 1, 0) != 0) begin n_bad++;
            $display("FAIL stall_image: writes %0d bad pixels %0d expected %0d and 0", wr_total - w0, img_bad(100, 50, 1, 0), exp_cost(100, 50, 1, 0, 1)); end
    endtask

    task automatic test_reset_mid_blit();
        int n, w0, d0, cyc; logic bz, dn;
        clear_fb(); rom_mode = 0; rom_const = 5'd3;
        wr_base_rdy = wr_total; rdy_mode = 2;
        w0 = wr_total; d0 = done_total;
        @(negedge Clk); bus.start = 1'b1; bus.pos_x = 10'd0; bus.pos_y = 10'd0;
        @(negedge Clk); bus.start = 1'b0;
        n = 0;
        while (!(bus.fb_we && !bus.fb_ready && (wr_total - w0) == 99) && n < 5000) begin @(negedge Clk); #1; n++; end
        n_cmp++; if (n >= 5000) begin n_bad++; $display("FAIL rst_reach_write100: cycles %0d budget 5000", n); end
        Reset = 1'b1;
        #1;
        n_cmp++; if ({bus.fb_we, bus.busy, bus.done} !== 3'b000) begin n_bad++;
            $display("FAIL rst_async: we/busy/done=%b expected 000", {bus.fb_we, bus.busy, bus.done}); end
        @(negedge Clk); @(posedge Clk); #1 Reset = 1'b0;
        rdy_mode = 0;
        repeat (10) @(negedge Clk);
        #1;
        n_cmp++; if (wr_total - w0 != 99 || done_total != d0 || bus.busy !== 1'b0) begin n_bad++;
            $display("FAIL rst_abandon: writes %0d done %0d busy %b expected 99 0 0", wr_total - w0, done_total - d0, bus.busy); end
        clear_fb(); w0 = wr_total;
        run_blit(10'd0, 10'd0, cyc, bz, dn);
        n_cmp++; if (cyc != 2835 || wr_total - w0 != 945 || done_total - d0 != 1) begin n_bad++;
            $display("FAIL rst_restart: cycles %0d writes %0d done %0d expected 2835 945 1", cyc, wr_total - w0, done_total - d0); end
    endtask

    task automatic test_start_ignored();
        int cyc, w0, d0;
        clear_fb(); rom_mode = 0; rom_const = 5'd9; rdy_mode = 0;
        w0 = wr_total; d0 = done_total;
        @(negedge Clk); bus.start = 1'b1; bus.pos_x = 10'd310; bus.pos_y = 10'd230;
        @(negedge Clk); bus.start = 1'b0;
        cyc = 0;
        repeat (5) begin @(negedge Clk); cyc++; end
        bus.start = 1'b1; bus.pos_x = 10'd0; bus.pos_y = 10'd0;
        @(negedge Clk); cyc++; bus.start = 1'b0;
        while (!bus.done && cyc < 20000) begin @(negedge Clk); cyc++; end
        bus.start = 1'b1;
        @(negedge Clk); bus.start = 1'b0;
        repeat (20) @(negedge Clk);
        #1;
        n_cmp++; if (cyc != 1145) begin n_bad++; $display("FAIL ign_cycles: got %0d expected 1145", cyc); end
        n_cmp++; if (done_total - d0 != 1 || wr_total - w0 != 100 || bus.busy !== 1'b0) begin n_bad++;
            $display("FAIL ign_once: done %0d writes %0d busy %b expected 1 100 0", done_total - d0, wr_total - w0, bus.busy); end
    endtask

    task automatic test_back_to_back();
        int cyc, w0, d0; logic bz;
        clear_fb(); rom_mode = 0; rom_const = 5'd4; rdy_mode = 0;
        w0 = wr_total; d0 = done_total;
        @(negedge Clk); bus.start = 1'b1; bus.pos_x = 10'd310; bus.pos_y = 10'd230;
        @(negedge Clk); bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 20000) begin @(negedge Clk); cyc++; end
        @(negedge Clk); bus.start = 1'b1; bus.pos_x = 10'd0; bus.pos_y = 10'd235;
        @(negedge Clk); bus.start = 1'b0; bz = bus.busy;
        cyc = 0;
        while (!bus.done && cyc < 20000) begin @(negedge Clk); cyc++; end
        repeat (3) @(negedge Clk);
        #1;
        n_cmp++; if (bz !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b expected 1", bz); end
        n_cmp++; if (cyc != 1155) begin n_bad++; $display("FAIL b2b_cycles: got %0d expected 1155", cyc); end
        n_cmp++; if (done_total - d0 != 2 || wr_total - w0 != 205) begin n_bad++;
            $display("FAIL b2b_count: done %0d writes %0d expected 2 205", done_total - d0, wr_total - w0); end
    endtask

    initial begin
        bus.start = 1'b0; bus.pos_x = '0; bus.pos_y = '0;
        test_reset();
        test_opaque();
        test_pattern();
        test_clip();
        test_stall();
        test_reset_mid_blit();
        test_start_ignored();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached after %0d comparisons", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
